// File: rtl/regfile_wb_scheduler.sv
// Purpose : shares the single register-file write port between N_SRC writeback sources and keeps the RAW/WAW scoreboard.
// Latency : a grant in cycle T appears on rf_rd_* in cycle T+1; hazard/iss_stall/wb_ready are combinational.
// Backpres: round-robin one-hot wb_ready; non-granted sources hold their request; one write per cycle with no bubbles.
//
// Ports:
//   clk, rst                      clock and synchronous active-low reset
//   wb_valid/wb_rd/wb_data        per-source writeback requests (source i at slice i)
//   wb_ready                      one-hot grant, a request is consumed on valid & ready
//   rf_rd_en/rf_rd_addr/rf_rd_data registered register-file write port
//   iss_en/iss_rd/iss_stall       issue-side destination claim and WAW stall
//   chk_rs1/chk_rs2/hazard        issue-side source operands and RAW hazard
//   flush                         clears every busy bit
//   busy_vec                      scoreboard state, bit 0 is always 0

module regfile_wb_scheduler #(
    parameter int XLEN  = 32,
    parameter int N_SRC = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_SRC-1:0]        wb_valid,
    input  logic [N_SRC*5-1:0]      wb_rd,
    input  logic [N_SRC*XLEN-1:0]   wb_data,
    output logic [N_SRC-1:0]        wb_ready,
    output logic                    rf_rd_en,
    output logic [4:0]              rf_rd_addr,
    output logic [XLEN-1:0]         rf_rd_data,
    input  logic                    iss_en,
    input  logic [4:0]              iss_rd,
    output logic                    iss_stall,
    input  logic [4:0]              chk_rs1,
    input  logic [4:0]              chk_rs2,
    output logic                    hazard,
    input  logic                    flush,
    output logic [31:0]             busy_vec
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] rr_ptr;
    logic [N_SRC-1:0] grant;
    logic             gnt_vld;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] rr_nxt;

    // Two passes instead of a modulo rotate: first search rr_ptr..N_SRC-1,
    // then wrap to 0..rr_ptr-1. The found flag keeps only the first hit.
    always_comb begin
        grant   = '0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (!gnt_vld && wb_valid[i] && (i >= int'(rr_ptr))) begin
                gnt_vld  = 1'b1;
                gnt_idx  = IDX_W'(i);
                grant[i] = 1'b1;
            end
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (!gnt_vld && wb_valid[i] && (i < int'(rr_ptr))) begin
                gnt_vld  = 1'b1;
                gnt_idx  = IDX_W'(i);
                grant[i] = 1'b1;
            end
        end
    end

    assign wb_ready = grant;

    always_comb begin
        if (gnt_idx == IDX_W'(N_SRC - 1)) begin
            rr_nxt = '0;
        end else begin
            rr_nxt = gnt_idx + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Winner's payload
    // ------------------------------------------------------------------
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant[i]) begin
                sel_rd   = wb_rd[5*i +: 5];
                sel_data = wb_data[XLEN*i +: XLEN];
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    logic        iss_set;
    logic [31:0] busy_nxt;

    // x0 is never busy, so neither check can fire for register 0.
    assign iss_stall = iss_en & busy_vec[iss_rd];
    assign hazard    = busy_vec[chk_rs1] | busy_vec[chk_rs2];
    assign iss_set   = iss_en & ~iss_stall & (iss_rd != 5'd0);

    // The clear comes from the write currently on the port (commit cycle),
    // so hazard stays high while the file is still being written. The set
    // is applied after the clear so a same-register set/clear leaves it busy.
    always_comb begin
        busy_nxt = busy_vec;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (rf_rd_en) begin
                busy_nxt[rf_rd_addr] = 1'b0;
            end
            if (iss_set) begin
                busy_nxt[iss_rd] = 1'b1;
            end
        end
        busy_nxt[0] = 1'b0;
    end

    // ------------------------------------------------------------------
    // Registered write stage and state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr     <= '0;
            rf_rd_en   <= 1'b0;
            rf_rd_addr <= '0;
            rf_rd_data <= '0;
            busy_vec   <= '0;
        end else begin
            busy_vec <= busy_nxt;
            // A grant to x0 is consumed but never reaches the file.
            rf_rd_en <= gnt_vld & (sel_rd != 5'd0);
            if (gnt_vld) begin
                rr_ptr     <= rr_nxt;
                rf_rd_addr <= sel_rd;
                rf_rd_data <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;

    localparam int XLEN  = 32;
    localparam int N_SRC = 3;

    logic                  clk;
    logic                  rst;
    logic [N_SRC-1:0]      wb_valid;
    logic [N_SRC*5-1:0]    wb_rd;
    logic [N_SRC*XLEN-1:0] wb_data;
    logic [N_SRC-1:0]      wb_ready;
    logic                  rf_rd_en;
    logic [4:0]            rf_rd_addr;
    logic [XLEN-1:0]       rf_rd_data;
    logic                  iss_en;
    logic [4:0]            iss_rd;
    logic                  iss_stall;
    logic [4:0]            chk_rs1;
    logic [4:0]            chk_rs2;
    logic                  hazard;
    logic                  flush;
    logic [31:0]           busy_vec;

    regfile_wb_scheduler #(.XLEN(XLEN), .N_SRC(N_SRC)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .wb_ready   (wb_ready),
        .rf_rd_en   (rf_rd_en),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .iss_en     (iss_en),
        .iss_rd     (iss_rd),
        .iss_stall  (iss_stall),
        .chk_rs1    (chk_rs1),
        .chk_rs2    (chk_rs2),
        .hazard     (hazard),
        .flush      (flush),
        .busy_vec   (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: architectural view of the block.
    logic [31:0]     m_busy;
    int              m_rr;
    logic            m_en;
    logic [4:0]      m_addr;
    logic [XLEN-1:0] m_data;
    bit              chk_on;
    int              last_gnt;

    // Observations sampled at the falling edge of the most recent step.
    logic [N_SRC-1:0] obs_ready;
    logic             obs_en;
    logic [4:0]       obs_addr;
    logic [XLEN-1:0]  obs_data;
    logic             obs_haz;
    logic             obs_stall;
    logic [31:0]      obs_busy;

    // One clock cycle: inputs are already driven; sample and compare at the
    // falling edge, advance the model, then move past the rising edge.
    task automatic step();
        int          idx;
        logic        exp_stall;
        logic [4:0]  srd;
        @(negedge clk);
        obs_ready = wb_ready;
        obs_en    = rf_rd_en;
        obs_addr  = rf_rd_addr;
        obs_data  = rf_rd_data;
        obs_haz   = hazard;
        obs_stall = iss_stall;
        obs_busy  = busy_vec;

        idx = -1;
        for (int k = 0; k < N_SRC; k++) begin
            int j;
            j = (m_rr + k) % N_SRC;
            if (idx < 0 && wb_valid[j]) idx = j;
        end
        exp_stall = iss_en && m_busy[iss_rd];

        if (chk_on) begin
            chk("wb_ready", 64'(obs_ready), (idx >= 0) ? 64'(1) << idx : 64'(0));
            chk("rf_rd_en", 64'(obs_en), 64'(m_en));
            if (m_en) begin
                chk("rf_rd_addr", 64'(obs_addr), 64'(m_addr));
                chk("rf_rd_data", 64'(obs_data), 64'(m_data));
            end
            chk("busy_vec", 64'(obs_busy), 64'(m_busy));
            chk("hazard", 64'(obs_haz), 64'(m_busy[chk_rs1] | m_busy[chk_rs2]));
            chk("iss_stall", 64'(obs_stall), 64'(exp_stall));
        end

        if (!rst) begin
            m_busy = '0;
            m_rr   = 0;
            m_en   = 1'b0;
            m_addr = '0;
            m_data = '0;
        end else begin
            if (flush) begin
                m_busy = '0;
            end else begin
                if (m_en) m_busy[m_addr] = 1'b0;
                if (iss_en && !exp_stall && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
            end
            m_en = 1'b0;
            if (idx >= 0) begin
                srd    = wb_rd[5*idx +: 5];
                m_en   = (srd != 5'd0);
                m_addr = srd;
                m_data = wb_data[XLEN*idx +: XLEN];
                m_rr   = (idx + 1) % N_SRC;
            end
        end
        last_gnt = idx;
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [4:0] rd, input logic [XLEN-1:0] d);
        wb_valid[i]          = 1'b1;
        wb_rd[5*i +: 5]      = rd;
        wb_data[XLEN*i +: XLEN] = d;
    endtask

    initial begin
        int n2;
        rst = 1'b0; wb_valid = '0; wb_rd = '0; wb_data = '0;
        iss_en = 1'b0; iss_rd = '0; chk_rs1 = '0; chk_rs2 = '0; flush = 1'b0;
        m_busy = '0; m_rr = 0; m_en = 1'b0; m_addr = '0; m_data = '0;
        chk_on = 1'b0; last_gnt = -1;
        @(posedge clk); #1;
        step();
        chk_on = 1'b1;

        // Reset: build some state, then reset it away.
        rst = 1'b1;
        set_src(1, 5'd4, 32'h1111_0004);
        iss_en = 1'b1; iss_rd = 5'd8;
        step();
        wb_valid = '0; iss_en = 1'b0;
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("rst_busy", 64'(obs_busy), 64'(0));
        chk("rst_en", 64'(obs_en), 64'(0));
        chk("rst_addr", 64'(obs_addr), 64'(0));
        chk("rst_data", 64'(obs_data), 64'(0));
        chk("rst_ready", 64'(obs_ready), 64'(0));

        // Burst from all three sources starting at rr_ptr=0.
        set_src(0, 5'd5, 32'hAAAA_0005);
        set_src(1, 5'd6, 32'hBBBB_0006);
        set_src(2, 5'd7, 32'hCCCC_0007);
        step();
        chk("burst_g0", 64'(obs_ready), 64'b001);
        wb_valid[0] = 1'b0;
        step();
        chk("burst_g1", 64'(obs_ready), 64'b010);
        chk("burst_w5", {27'd0, obs_addr, obs_data}, {27'd0, 5'd5, 32'hAAAA_0005});
        wb_valid[1] = 1'b0;
        step();
        chk("burst_g2", 64'(obs_ready), 64'b100);
        chk("burst_w6", {27'd0, obs_addr, obs_data}, {27'd0, 5'd6, 32'hBBBB_0006});
        wb_valid[2] = 1'b0;
        step();
        chk("burst_w7", {27'd0, obs_addr, obs_data}, {27'd0, 5'd7, 32'hCCCC_0007});

        // Fairness between two always-requesting sources.
        set_src(0, 5'd1, 32'h0000_0101);
        set_src(1, 5'd2, 32'h0000_0202);
        for (int c = 0; c < 6; c++) begin
            step();
            chk("fair_gnt", 64'(last_gnt), 64'(c % 2));
        end
        set_src(2, 5'd3, 32'h0000_0303);
        n2 = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (last_gnt == 2) n2++;
        end
        chk("src2_served", 64'(n2 > 0), 64'(1));
        wb_valid = '0;
        step();

        // RAW hazard lifetime across the commit cycle.
        chk_rs1 = 5'd10; chk_rs2 = 5'd0;
        iss_en = 1'b1; iss_rd = 5'd10;
        step();
        chk("raw_issue_stall", 64'(obs_stall), 64'(0));
        iss_en = 1'b0;
        step();
        chk("raw_haz_busy", 64'(obs_haz), 64'(1));
        set_src(1, 5'd10, 32'hDEAD_000A);
        step();
        chk("raw_haz_grant", 64'(obs_haz), 64'(1));
        wb_valid = '0;
        step();
        chk("raw_haz_commit", 64'(obs_haz), 64'(1));
        chk("raw_commit_addr", 64'(obs_addr), 64'(10));
        step();
        chk("raw_haz_after", 64'(obs_haz), 64'(0));

        // Same-cycle set and clear of x10 keeps it busy.
        set_src(0, 5'd10, 32'h0000_AAAA);
        step();
        wb_valid = '0;
        iss_en = 1'b1; iss_rd = 5'd10;
        step();
        chk("setclr_en", 64'(obs_en), 64'(1));
        chk("setclr_stall", 64'(obs_stall), 64'(0));
        iss_en = 1'b0;
        step();
        chk("setclr_busy10", 64'(obs_busy), 64'(32'h0000_0400));
        // Issue to x0 claims nothing.
        iss_en = 1'b1; iss_rd = 5'd0;
        step();
        chk("x0_stall", 64'(obs_stall), 64'(0));
        iss_en = 1'b0;
        step();
        chk("x0_busy", 64'(obs_busy), 64'(32'h0000_0400));
        // Writeback to x0 is consumed without a write.
        set_src(2, 5'd0, 32'hFFFF_FFFF);
        step();
        chk("x0_wb_ready", 64'(obs_ready), 64'b100);
        wb_valid = '0;
        step();
        chk("x0_wb_en", 64'(obs_en), 64'(0));

        // Flush with a grant in flight.
        iss_en = 1'b1; iss_rd = 5'd3;
        step();
        iss_rd = 5'd4;
        step();
        iss_en = 1'b0;
        step();
        chk("flush_pre_busy", 64'(obs_busy), 64'(32'h0000_0418));
        set_src(0, 5'd9, 32'h0909_0909);
        flush = 1'b1; iss_en = 1'b1; iss_rd = 5'd12;
        step();
        chk("flush_grant", 64'(obs_ready), 64'b001);
        flush = 1'b0; iss_en = 1'b0; wb_valid = '0;
        step();
        chk("flush_busy", 64'(obs_busy), 64'(0));
        chk("flush_write", {31'd0, obs_en, obs_addr, obs_data}, {31'd0, 1'b1, 5'd9, 32'h0909_0909});

        // Reset during a grant discards the write.
        set_src(1, 5'd11, 32'h0B0B_0B0B);
        rst = 1'b0;
        step();
        wb_valid = '0; rst = 1'b1;
        step();
        chk("rst_grant_en", 64'(obs_en), 64'(0));

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            if (last_gnt >= 0) wb_valid[last_gnt] = 1'b0;
            for (int i = 0; i < N_SRC; i++) begin
                if (!wb_valid[i] && ($urandom_range(0, 1) == 1)) begin
                    set_src(i, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                            $urandom);
                end
            end
            iss_en  = ($urandom_range(0, 2) != 0);
            iss_rd  = 5'($urandom_range(0, 31));
            chk_rs1 = 5'($urandom_range(0, 31));
            chk_rs2 = 5'($urandom_range(0, 31));
            flush   = ($urandom_range(0, 15) == 0);
            rst     = ($urandom_range(0, 49) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
